// File: rtl/pad_poll_pkg.sv
// Shared types and default timing constants for the pad poll scheduler.
package pad_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOW,
        HIGH,
        DONE
    } state_e;

    localparam int DEF_POLL_PERIOD = 833333;
    localparam int DEF_LATCH_CYC   = 600;
    localparam int DEF_HALF_CYC    = 300;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pad_shift_capture.sv
// One pad lane: 2-flop synchronizer on the serial data wire and an indexed
// capture register that stores the inverted (active-high) button bit.
module pad_shift_capture #(
    parameter int NUM_BITS = 8,
    parameter int K_W      = 3
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                data_in,
    input  logic                cap_en,
    input  logic [K_W-1:0]      bit_idx,
    output logic [NUM_BITS-1:0] sr_out
);

    logic                sync1_q, sync2_q;
    logic [NUM_BITS-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (cap_en) begin
            sr_d[bit_idx] = ~sync2_q;
        end
    end

    // Synchronizers reset to the released (not pressed) line level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sr_q    <= '0;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
            sr_q    <= sr_d;
        end
    end

    assign sr_out = sr_q;

endmodule

// File: rtl/pad_poll_scheduler.sv
// Latch/pulse poll sequencer for NUM_PADS serial game pads with periodic or
// on-demand polling. Macro PAD_EDGE_DETECT_EN enables the newly-pressed output.
module pad_poll_scheduler
    import pad_poll_pkg::*;
#(
    parameter int NUM_PADS    = 2,
    parameter int NUM_BITS    = 8,
    parameter int POLL_PERIOD = DEF_POLL_PERIOD,
    parameter int LATCH_CYC   = DEF_LATCH_CYC,
    parameter int HALF_CYC    = DEF_HALF_CYC
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         auto_en,
    input  logic                         poll_req,
    input  logic [NUM_PADS-1:0]          data,
    output logic                         latch,
    output logic                         pulse,
    output logic                         busy,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed
);

    localparam int PH_MAX = max2(LATCH_CYC, HALF_CYC);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int K_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int T_W    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int FW     = NUM_PADS * NUM_BITS;

    state_e         state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [T_W-1:0]  timer_q, timer_d;
    logic            pending_q, pending_d;
    logic            latch_q, latch_d, pulse_q, pulse_d, busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [FW-1:0]   buttons_q, buttons_d;
    logic [FW-1:0]   frame;
    logic            tick, cap_en, frame_upd;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        pad_shift_capture #(
            .NUM_BITS (NUM_BITS),
            .K_W      (K_W)
        ) u_cap (
            .clk     (clk),
            .n_rst   (n_rst),
            .data_in (data[p]),
            .cap_en  (cap_en),
            .bit_idx (k_q),
            .sr_out  (frame[p*NUM_BITS +: NUM_BITS])
        );
    end

    always_comb begin
        tick      = auto_en && (timer_q == T_W'(POLL_PERIOD - 1));
        timer_d   = (!auto_en || tick) ? '0 : timer_q + T_W'(1);
        pending_d = pending_q | tick | poll_req;
        state_d   = state_q;
        ph_d      = ph_q;
        k_d       = k_q;
        cap_en    = 1'b0;
        frame_upd = 1'b0;

        case (state_q)
            IDLE: begin
                // Anything arriving in the start cycle merges into this poll.
                if (pending_q) begin
                    pending_d = 1'b0;
                    ph_d      = PH_W'(LATCH_CYC - 1);
                    state_d   = LATCH;
                end
            end
            LATCH: begin
                if (ph_q == '0) begin
                    ph_d    = PH_W'(HALF_CYC - 1);
                    k_d     = '0;
                    state_d = LOW;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            LOW: begin
                if (ph_q == '0) begin
                    cap_en  = 1'b1;
                    ph_d    = PH_W'(HALF_CYC - 1);
                    state_d = (k_q == K_W'(NUM_BITS - 1)) ? DONE : HIGH;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            HIGH: begin
                if (ph_q == '0) begin
                    ph_d    = PH_W'(HALF_CYC - 1);
                    k_d     = k_q + K_W'(1);
                    state_d = LOW;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            DONE: begin
                frame_upd = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so pins never glitch.
        latch_d   = (state_d == LATCH);
        pulse_d   = (state_d == HIGH);
        busy_d    = (state_d != IDLE);
        valid_d   = frame_upd;
        buttons_d = frame_upd ? frame : buttons_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            k_q       <= '0;
            timer_q   <= '0;
            pending_q <= 1'b0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            k_q       <= k_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            buttons_q <= buttons_d;
        end
    end

`ifdef PAD_EDGE_DETECT_EN
    // buttons_q still holds the previous frame during the DONE cycle.
    logic [FW-1:0] pressed_q, pressed_d;

    always_comb begin
        pressed_d = frame_upd ? (frame & ~buttons_q) : pressed_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pressed_q <= '0;
        end else begin
            pressed_q <= pressed_d;
        end
    end

    assign pressed = pressed_q;
`else
    assign pressed = '0;
`endif

    assign latch   = latch_q;
    assign pulse   = pulse_q;
    assign busy    = busy_q;
    assign valid   = valid_q;
    assign buttons = buttons_q;

endmodule

// File: tb/tb_pad_poll_scheduler.sv
// Directed bench for pad_poll_scheduler with a behavioural two-pad model.
module tb_pad_poll_scheduler;

    localparam int NP = 2;
    localparam int NB = 8;
    localparam int PERIOD = 100;
    localparam int LCYC = 6;
    localparam int HCYC = 4;
`ifdef PAD_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic           auto_en = 1'b0;
    logic           poll_req = 1'b0;
    logic [NP-1:0]  data = '1;
    logic           latch, pulse, busy, valid;
    logic [NP*NB-1:0] buttons, pressed;

    pad_poll_scheduler #(
        .NUM_PADS    (NP),
        .NUM_BITS    (NB),
        .POLL_PERIOD (PERIOD),
        .LATCH_CYC   (LCYC),
        .HALF_CYC    (HCYC)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .auto_en  (auto_en),
        .poll_req (poll_req),
        .data     (data),
        .latch    (latch),
        .pulse    (pulse),
        .busy     (busy),
        .buttons  (buttons),
        .valid    (valid),
        .pressed  (pressed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pad model and output monitor, all on the falling edge.
    logic [NB-1:0] pad_val [NP];
    logic [NB-1:0] pad_sr [NP];
    int cyc = 0;
    int latch_rise_n, pulse_rise_n, valid_n, busy_n, latch_hi_n;
    int latch_bad, pulse_bad, lrun, prun;
    int rise_cyc [$];
    logic latch_prev = 1'b0, pulse_prev = 1'b0;

    task automatic clr();
        latch_rise_n = 0; pulse_rise_n = 0; valid_n = 0; busy_n = 0;
        latch_hi_n = 0; latch_bad = 0; pulse_bad = 0; lrun = 0; prun = 0;
        rise_cyc.delete();
    endtask

    initial begin
        clr();
        for (int p = 0; p < NP; p++) begin
            pad_val[p] = '1;
            pad_sr[p]  = '1;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (latch && !latch_prev) begin
                latch_rise_n++;
                rise_cyc.push_back(cyc);
                lrun = 0;
            end
            if (latch) begin
                lrun++;
                latch_hi_n++;
            end
            if (!latch && latch_prev && lrun != LCYC) latch_bad++;
            if (pulse && !pulse_prev) begin
                pulse_rise_n++;
                prun = 0;
            end
            if (pulse) prun++;
            if (!pulse && pulse_prev && prun != HCYC) pulse_bad++;
            if (busy) busy_n++;
            if (valid) valid_n++;
            for (int p = 0; p < NP; p++) begin
                if (latch) pad_sr[p] = pad_val[p];
                else if (pulse && !pulse_prev) pad_sr[p] = {1'b1, pad_sr[p][NB-1:1]};
                data[p] = pad_sr[p][0];
            end
            latch_prev = latch;
            pulse_prev = pulse;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req();
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        idle(3);
        n_rst = 1'b1;
        idle(2);
    endtask

    int d0, d1;

    initial begin
        // Reset state
        #1;
        chk("rst_latch", latch, 0);
        chk("rst_pulse", pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_buttons", buttons, 0);
        chk("rst_pressed", pressed, 0);
        idle(3);
        n_rst = 1'b1;
        idle(2);

        // Single requested poll: pad0 0x5A on the wire, pad1 released
        pad_val[0] = 8'h5A;
        pad_val[1] = 8'hFF;
        clr();
        req();
        idle(100);
        chk("t1_latch_cycles", latch_hi_n, LCYC);
        chk("t1_pulses", pulse_rise_n, 7);
        chk("t1_pulse_width_bad", pulse_bad, 0);
        chk("t1_busy_cycles", busy_n, 67);
        chk("t1_valid_count", valid_n, 1);
        chk("t1_pad0", buttons[7:0], 8'hA5);
        chk("t1_pad1", buttons[15:8], 8'h00);

        // Auto mode for 300 cycles
        clr();
        @(negedge clk);
        auto_en = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        auto_en = 1'b0;
        idle(100);
        chk("t2_polls", latch_rise_n, 3);
        chk("t2_valids", valid_n, 3);
        chk("t2_pulses", pulse_rise_n, 21);
        chk("t2_latch_glitch", latch_bad, 0);
        chk("t2_pulse_glitch", pulse_bad, 0);
        d0 = (rise_cyc.size() >= 3) ? rise_cyc[1] - rise_cyc[0] : -1;
        d1 = (rise_cyc.size() >= 3) ? rise_cyc[2] - rise_cyc[1] : -1;
        chk("t2_spacing_a", d0, PERIOD);
        chk("t2_spacing_b", d1, PERIOD);

        // Three requests during busy coalesce into one follow-up poll
        clr();
        req();
        idle(8);
        req();
        idle(18);
        req();
        idle(18);
        req();
        idle(200);
        chk("t3_polls", latch_rise_n, 2);
        chk("t3_valids", valid_n, 2);
        d0 = (rise_cyc.size() >= 2) ? rise_cyc[1] - rise_cyc[0] : -1;
        chk("t3_restart_gap", d0, 68);

        // Timer wrap and request in the same cycle
        clr();
        @(negedge clk);
        auto_en = 1'b1;
        idle(99);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        auto_en = 1'b0;
        idle(200);
        chk("t4_polls", latch_rise_n, 1);
        chk("t4_valids", valid_n, 1);

        // Reset in the middle of a poll
        req();
        idle(30);
        chk("t5_busy_before", busy, 1);
        n_rst = 1'b0;
        #1;
        chk("t5_latch", latch, 0);
        chk("t5_pulse", pulse, 0);
        chk("t5_busy", busy, 0);
        chk("t5_valid", valid, 0);
        chk("t5_buttons", buttons, 0);
        idle(3);
        n_rst = 1'b1;
        idle(1);
        clr();
        idle(100);
        chk("t5_no_resume", latch_rise_n, 0);
        chk("t5_buttons_hold", buttons, 0);
        pad_val[0] = 8'h3C;
        pad_val[1] = 8'h00;
        clr();
        req();
        idle(100);
        chk("t5_new_valid", valid_n, 1);
        chk("t5_new_frame", buttons, 16'hFFC3);

        // Newly-pressed detection across two frames
        do_reset();
        pad_val[0] = 8'hFE;
        pad_val[1] = 8'hFF;
        req();
        idle(100);
        chk("t6_frame1", buttons[7:0], 8'h01);
        chk("t6_pressed1", pressed[7:0], EDGE_EN ? 8'h01 : 8'h00);
        pad_val[0] = 8'hFC;
        req();
        idle(100);
        chk("t6_frame2", buttons[7:0], 8'h03);
        chk("t6_pressed2", pressed[7:0], EDGE_EN ? 8'h02 : 8'h00);
        chk("t6_pressed2_pad1", pressed[15:8], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pad_poll_scheduler.md
Name: pad_poll_scheduler

Overview:
- Synchronous poll sequencer for up to NUM_PADS serial game pads that share one latch wire and one pulse wire, each with its own data wire.
- Generates latch and pulse timing from the system clock only; no derived clocks.
- Captures all pads in parallel and publishes frames with a one-cycle valid strobe.
- Polls either periodically (auto mode) or on request; sits between the pad pins and game logic.

Parameters:
- NUM_PADS, 2, number of pads sharing latch and pulse.
- NUM_BITS, 8, bits shifted per pad per poll.
- POLL_PERIOD, 833333, auto-poll interval in clk cycles (60 Hz at 50 MHz).
- LATCH_CYC, 600, latch high time in cycles.
- HALF_CYC, 300, pulse low/high phase length in cycles; must be ≥ 4.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- n_rst  input  1  reset, asynchronous, active-low.
- auto_en  input  1  enables the periodic poll timer.
- poll_req  input  1  single-cycle request for an immediate poll.
- data  input  NUM_PADS  pad serial data, active-low (0 = pressed), asynchronous to clk.
- latch  output  1  shared pad latch.
- pulse  output  1  shared pad shift clock.
- busy  output  1  high while a poll sequence runs.
- buttons  output  NUM_PADS*NUM_BITS  last complete frame, active-high; pad p occupies bits [p*NUM_BITS +: NUM_BITS], bit 0 = first bit shifted.
- valid  output  1  one-cycle strobe when buttons updates.
- pressed  output  NUM_PADS*NUM_BITS  newly-pressed bits of the current frame (optional feature).

Behaviour:
- Reset values: latch=0, pulse=0, busy=0, buttons=0, valid=0, pressed=0, pending=0, timer=0, FSM=IDLE.
- Each data bit passes through a 2-flop synchronizer before use.
- Period timer:
  - Counts 0..POLL_PERIOD-1 while auto_en=1.
  - On wrap it sets pending.
  - Held at 0 while auto_en=0.
- poll_req sets pending.
- Requests and ticks arriving while pending is already set or busy=1 coalesce into a single pending poll. A tick and a req in the same cycle produce one poll.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE.
  - IDLE: when pending=1, clear pending, load phase counter, go to LATCH. latch and busy rise in the next cycle.
  - LATCH: latch=1 for LATCH_CYC cycles, then go to LOW with bit index k=0.
  - LOW: pulse=0 for HALF_CYC cycles. On the last cycle, shift the inverted synchronized data of every pad into bit k.
    - If k=NUM_BITS-1, go to DONE.
    - Otherwise go to HIGH.
  - HIGH: pulse=1 for HALF_CYC cycles, then k=k+1 and go to LOW.
  - DONE: one cycle. buttons takes the shift registers, valid=1, then go to IDLE. busy=0 from the IDLE cycle on.
- busy duration: LATCH_CYC + NUM_BITS*HALF_CYC + (NUM_BITS-1)*HALF_CYC + 1 cycles. There are NUM_BITS-1 pulses.
- A poll pending at DONE starts on the cycle after DONE, from IDLE.
- buttons is stable except in the DONE update cycle; partial frames are never visible.
- Phase counter width: $clog2 of max(LATCH_CYC, HALF_CYC). Bit index width: $clog2(NUM_BITS).
- Reset mid-poll aborts immediately to reset values; no frame is published.

Optional Feature:
- Macro PAD_EDGE_DETECT_EN.
- Defined: keep the previous frame register. In the DONE cycle, pressed <= new_frame & ~old_frame, and pressed holds until the next DONE. The first frame after reset compares against 0.
- Undefined: no previous-frame register; the pressed port is tied to 0.

Decomposition:
- Package pad_poll_pkg:
  - state enum (IDLE, LATCH, LOW, HIGH, DONE).
  - default constants for POLL_PERIOD, LATCH_CYC, HALF_CYC.
- One sub-module, pad_shift_capture: per-pad 2-flop synchronizer plus NUM_BITS shift register with capture enable and bit index. Instantiated NUM_PADS times with generate.

Test Plan (params NUM_PADS=2, NUM_BITS=8, POLL_PERIOD=100, LATCH_CYC=6, HALF_CYC=4):
- poll_req pulse, auto_en=0, pad0 driving 0x5A (active-low, first bit = LSB), pad1 all 1s -> latch high 6 cycles, 7 pulses each 4 cycles high, busy high 67 cycles, valid once, buttons[7:0]=0xA5, buttons[15:8]=0x00.
- auto_en=1 held for 300 cycles -> exactly 3 polls, started 100 cycles apart; no glitches on latch or pulse.
- poll_req asserted 3 times during busy -> exactly one extra poll, starting 1 cycle after DONE.
- Timer wrap and poll_req in the same cycle -> single poll; pending clear afterwards.
- n_rst asserted at cycle 30 of a poll -> latch, pulse, busy, valid at 0 immediately; buttons keeps reset value 0; a new poll_req works normally.
- PAD_EDGE_DETECT_EN: frames 0x01 then 0x03 on pad0 -> pressed[7:0]=0x01 then 0x02; with macro undefined, pressed stays 0.
